// File: rtl/proj_read_sched.sv
// proj_read_sched
// Read-level controller in front of the MinHash pipeline core. It forwards
// upstream bases one per cycle, caps each read at READ_LEN bases, and then
// appends DRAIN_CYCLES pad beats so the core finishes its index sweep before
// the next read enters. Core back-pressure (core_wait) stalls both the base
// stream and the pad drain.
module proj_read_sched #(
  parameter int                  BASE_LEN     = 2,
  parameter int                  READ_LEN     = 1024,
  parameter int                  DRAIN_CYCLES = 64,
  parameter logic [BASE_LEN-1:0] PAD_BASE     = {BASE_LEN{1'b0}},
  parameter int                  CNT_W        = 16,
  localparam int                 LEN_W        = $clog2(READ_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  input  logic [BASE_LEN-1:0] s_base,
  input  logic                s_last,
  output logic                s_ready,
  input  logic                core_wait,
  input  logic                abort,
  output logic [BASE_LEN-1:0] core_base,
  output logic                core_valid,
  output logic                read_done,
  output logic [LEN_W-1:0]    read_len,
  output logic                read_trunc,
  output logic [CNT_W-1:0]    read_count,
  output logic                busy
);

  localparam int               DRN_W     = $clog2(DRAIN_CYCLES + 1);
  localparam logic [LEN_W-1:0] LAST_IDX  = LEN_W'(READ_LEN - 1);
  localparam logic [DRN_W-1:0] DRAIN_END = DRN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [LEN_W-1:0]    base_cnt_r;
  logic [LEN_W-1:0]    base_cnt_nxt_s;
  logic [DRN_W-1:0]    drain_cnt_r;
  logic [DRN_W-1:0]    drain_cnt_nxt_s;
  logic                trunc_q_r;
  logic                trunc_q_nxt_s;
  logic [BASE_LEN-1:0] core_base_r;
  logic [BASE_LEN-1:0] core_base_nxt_s;
  logic                core_valid_r;
  logic                core_valid_nxt_s;
  logic                read_done_r;
  logic                read_done_nxt_s;
  logic [LEN_W-1:0]    read_len_r;
  logic [LEN_W-1:0]    read_len_nxt_s;
  logic                read_trunc_r;
  logic                read_trunc_nxt_s;
  logic [CNT_W-1:0]    read_count_r;
  logic [CNT_W-1:0]    read_count_nxt_s;
  logic                busy_r;

  logic                ready_s;
  logic                xfer_s;
  logic                at_limit_s;
  logic                drain_end_s;

  // Upstream handshake: accept only while streaming, the core is not stalling
  // and no abort is being applied this cycle.
  always_comb begin
    ready_s = 1'b0;
    if ((state_r == ST_STREAM) && !core_wait && !abort) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign xfer_s      = s_valid && ready_s;
  assign at_limit_s  = (base_cnt_r == LAST_IDX);
  assign drain_end_s = (drain_cnt_r == DRAIN_END);

  // Next-state and next-output decode; abort overrides every state.
  always_comb begin
    state_nxt_s      = state_r;
    base_cnt_nxt_s   = base_cnt_r;
    drain_cnt_nxt_s  = drain_cnt_r;
    trunc_q_nxt_s    = trunc_q_r;
    core_base_nxt_s  = core_base_r;
    core_valid_nxt_s = 1'b0;
    read_done_nxt_s  = 1'b0;
    read_len_nxt_s   = read_len_r;
    read_trunc_nxt_s = read_trunc_r;
    read_count_nxt_s = read_count_r;
    if (abort) begin
      state_nxt_s      = ST_IDLE;
      base_cnt_nxt_s   = {LEN_W{1'b0}};
      drain_cnt_nxt_s  = {DRN_W{1'b0}};
      core_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          base_cnt_nxt_s = {LEN_W{1'b0}};
          // The first base is not consumed here; STREAM takes it next cycle.
          if (s_valid) begin
            state_nxt_s = ST_STREAM;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (xfer_s) begin
            base_cnt_nxt_s   = base_cnt_r + LEN_W'(1);
            core_base_nxt_s  = s_base;
            core_valid_nxt_s = 1'b1;
            if (s_last || at_limit_s) begin
              state_nxt_s   = ST_DRAIN;
              trunc_q_nxt_s = at_limit_s && !s_last;
            end else begin
              state_nxt_s = ST_STREAM;
            end
          end else begin
            // Bubble: core_base keeps its last value, core_valid drops.
            core_valid_nxt_s = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            // Last pad beat is on the bus now; report the read.
            state_nxt_s      = ST_IDLE;
            drain_cnt_nxt_s  = {DRN_W{1'b0}};
            read_done_nxt_s  = 1'b1;
            read_len_nxt_s   = base_cnt_r;
            read_trunc_nxt_s = trunc_q_r;
            read_count_nxt_s = read_count_r + CNT_W'(1);
          end else if (!core_wait) begin
            core_base_nxt_s  = PAD_BASE;
            core_valid_nxt_s = 1'b1;
            drain_cnt_nxt_s  = drain_cnt_r + DRN_W'(1);
          end else begin
            core_valid_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          base_cnt_nxt_s  = {LEN_W{1'b0}};
          drain_cnt_nxt_s = {DRN_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      base_cnt_r   <= {LEN_W{1'b0}};
      drain_cnt_r  <= {DRN_W{1'b0}};
      trunc_q_r    <= 1'b0;
      core_base_r  <= {BASE_LEN{1'b0}};
      core_valid_r <= 1'b0;
      read_done_r  <= 1'b0;
      read_len_r   <= {LEN_W{1'b0}};
      read_trunc_r <= 1'b0;
      read_count_r <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      base_cnt_r   <= base_cnt_nxt_s;
      drain_cnt_r  <= drain_cnt_nxt_s;
      trunc_q_r    <= trunc_q_nxt_s;
      core_base_r  <= core_base_nxt_s;
      core_valid_r <= core_valid_nxt_s;
      read_done_r  <= read_done_nxt_s;
      read_len_r   <= read_len_nxt_s;
      read_trunc_r <= read_trunc_nxt_s;
      read_count_r <= read_count_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign s_ready    = ready_s;
  assign core_base  = core_base_r;
  assign core_valid = core_valid_r;
  assign read_done  = read_done_r;
  assign read_len   = read_len_r;
  assign read_trunc = read_trunc_r;
  assign read_count = read_count_r;
  assign busy       = busy_r;

endmodule
